// File: rtl/quadrature_decoder_gen2.sv
// Quadrature decoder with synchronised, glitch-filtered inputs, X1/X2/X4 decoding,
// index homing, illegal-transition flag and gated speed measurement.
module quadrature_decoder_gen2 #(
  parameter int CNT_W = 32,
  parameter int FILT  = 3,
  parameter int MODE  = 4,
  parameter int GATE  = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a,
  input  logic                    b,
  input  logic                    z,
  input  logic                    latch,
  input  logic                    clear,
  input  logic                    index_clr_en,
  input  logic                    err_clr,
  output logic signed [CNT_W-1:0] counter,
  output logic signed [CNT_W-1:0] counter_latched,
  output logic signed [CNT_W-1:0] speed,
  output logic                    cw,
  output logic                    ccw,
  output logic                    dir,
  output logic                    err
);

  localparam int GW = (GATE > 2) ? $clog2(GATE) : 1;
  localparam logic [3:0] FILT_LAST = 4'(FILT - 1);
  localparam logic [4:0] ARM_LEN = 5'(FILT + 2);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE - 1);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0] ONE_X = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SAT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] SAT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] filt;
  logic [3:0] filt_cnt [3];
  logic [4:0] arm_cnt;
  logic       armed;

  logic [1:0] cur_ab;
  logic [1:0] prev_ab;
  logic       z_prev;
  logic       z_rise;

  logic step4_cw, step4_ccw, illegal;
  logic a_rise, a_chg;
  logic step_cw, step_ccw;
  logic block, count_cw, count_ccw;

  logic latch_d, latch_pulse;

  logic [GW-1:0]           gate_cnt;
  logic signed [CNT_W-1:0] acc;
  logic signed [CNT_W:0]   acc_sum;
  logic signed [CNT_W-1:0] acc_next;

  assign raw    = {z, b, a};
  assign armed  = (arm_cnt == ARM_LEN);
  assign cur_ab = {filt[0], filt[1]};
  assign z_rise = armed & filt[2] & ~z_prev;

  // While arming, the filtered values follow the synchroniser directly so the
  // decoder wakes up already agreeing with the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      filt    <= '0;
      arm_cnt <= '0;
      for (int i = 0; i < 3; i++) filt_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (!armed) arm_cnt <= arm_cnt + 5'd1;
      for (int i = 0; i < 3; i++) begin
        if (!armed) begin
          filt[i]     <= sync2[i];
          filt_cnt[i] <= '0;
        end else if (sync2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_LAST) begin
          filt[i]     <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    step4_cw  = 1'b0;
    step4_ccw = 1'b0;
    illegal   = 1'b0;
    if (armed) begin
      case ({prev_ab, cur_ab})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step4_cw  = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step4_ccw = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal   = 1'b1;
        default: ;
      endcase
    end
    a_chg = prev_ab[1] ^ cur_ab[1];
    a_rise = ~prev_ab[1] & cur_ab[1];
    if (MODE == 1) begin
      step_cw  = step4_cw & a_rise;
      step_ccw = step4_ccw & a_rise;
    end else if (MODE == 2) begin
      step_cw  = step4_cw & a_chg;
      step_ccw = step4_ccw & a_chg;
    end else begin
      step_cw  = step4_cw;
      step_ccw = step4_ccw;
    end
    block     = clear | (index_clr_en & z_rise);
    count_cw  = step_cw & ~block;
    count_ccw = step_ccw & ~block;
  end

  // Speed accumulator saturates rather than wrapping so a runaway window
  // reports full scale instead of a sign-flipped value.
  always_comb begin
    acc_sum = {acc[CNT_W-1], acc};
    if (step_cw)       acc_sum = acc_sum + ONE_X;
    else if (step_ccw) acc_sum = acc_sum - ONE_X;
    if (acc_sum[CNT_W] != acc_sum[CNT_W-1])
      acc_next = acc_sum[CNT_W] ? SAT_MIN : SAT_MAX;
    else
      acc_next = acc_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ab         <= '0;
      z_prev          <= 1'b0;
      counter         <= '0;
      counter_latched <= '0;
      speed           <= '0;
      cw              <= 1'b0;
      ccw             <= 1'b0;
      dir             <= 1'b0;
      err             <= 1'b0;
      latch_d         <= 1'b0;
      latch_pulse     <= 1'b0;
      gate_cnt        <= '0;
      acc             <= '0;
    end else begin
      prev_ab <= cur_ab;
      z_prev  <= filt[2];

      if (clear)                      counter <= '0;
      else if (index_clr_en & z_rise) counter <= '0;
      else if (step_cw)               counter <= counter + ONE;
      else if (step_ccw)              counter <= counter - ONE;

      cw  <= count_cw;
      ccw <= count_ccw;
      if (count_cw)       dir <= 1'b1;
      else if (count_ccw) dir <= 1'b0;

      if (illegal)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      latch_d     <= latch;
      latch_pulse <= latch & ~latch_d;
      if (latch_pulse) counter_latched <= counter;

      if (gate_cnt == GATE_LAST) begin
        gate_cnt <= '0;
        speed    <= acc_next;
        acc      <= '0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        acc      <= acc_next;
      end
    end
  end

endmodule
